cache_ctrl: RTL

Controller that drives the 64-entry direct-mapped, 4-word/line cache array (write-back, write-allocate). It sits between the CPU load/store port and unified memory. It issues cache read and write strobes and judges hit/dirty. On a miss it evicts dirty victims, fills lines, and merges store words.

---
 rtl/cache_ctrl_pkg.sv | 29 ++
 rtl/cache_ctrl_line.sv | 27 ++
 rtl/cache_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding, field geometry and helpers for the cache controller.
package cache_ctrl_pkg;

   localparam int TAG_W      = 5;
   localparam int IDX_W      = 6;
   localparam int WORD_SEL_W = 2;
   localparam int LINE_W     = 64;
   localparam int WORD_W     = 16;
   localparam int CPU_ADDR_W = 16;
   localparam int WAIT_W     = 8;
   localparam int LADDR_W    = TAG_W + IDX_W;
   localparam int WORDS      = LINE_W / WORD_W;

   // The line address {tag,index} sits directly above the word select.
   localparam int LADDR_LSB  = WORD_SEL_W;
   localparam int LADDR_MSB  = WORD_SEL_W + LADDR_W - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WB    = 2'd1,
      FILL  = 2'd2,
      ALLOC = 2'd3
   } state_e;

   function automatic logic [WAIT_W-1:0] wait_step(input logic [WAIT_W-1:0] cnt);
      return (cnt == '1) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/cache_ctrl_line.sv
// Word select and single-word replace on a cache line; shared by the
// hit-store and allocate write paths.
module line_merge
   import cache_ctrl_pkg::*;
(
   input  logic [LINE_W-1:0]     line_in,
   input  logic [WORD_SEL_W-1:0] word_sel,
   input  logic [WORD_W-1:0]     new_word,
   input  logic                  replace_en,
   output logic [WORD_W-1:0]     word_out,
   output logic [LINE_W-1:0]     line_out
);

   logic [WORD_W-1:0] words [WORDS];

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_word
         assign words[gi] = line_in[gi*WORD_W +: WORD_W];
         assign line_out[gi*WORD_W +: WORD_W] =
            (replace_en && (word_sel == WORD_SEL_W'(gi))) ? new_word : words[gi];
      end
   endgenerate

   assign word_out = words[word_sel];

endmodule

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate controller for a 64-line direct-mapped cache.
// Optional snoop lookup port compiled in with `define CACHE_SNOOP_EN.
module cache_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_re,
   input  logic                  cpu_we,
   input  logic [CPU_ADDR_W-1:0] cpu_addr,
   input  logic [WORD_W-1:0]     cpu_wdata,
   output logic [WORD_W-1:0]     cpu_rdata,
   output logic                  cpu_stall,
   output logic [LADDR_W-1:0]    c_addr,
   output logic [LINE_W-1:0]     c_wr_data,
   output logic                  c_wdirty,
   output logic                  c_we,
   output logic                  c_re,
   input  logic [LINE_W-1:0]     c_rd_data,
   input  logic [TAG_W-1:0]      c_tag_out,
   input  logic                  c_hit,
   input  logic                  c_dirty,
   output logic [LADDR_W-1:0]    m_addr,
   output logic [LINE_W-1:0]     m_wdata,
   output logic                  m_re,
   output logic                  m_we,
   input  logic [LINE_W-1:0]     m_rdata,
   input  logic                  m_rdy,
`ifdef CACHE_SNOOP_EN
   input  logic                  snoop_req,
   input  logic [LADDR_W-1:0]    snoop_addr,
   output logic                  snoop_found,
   output logic                  c_search,
`endif
   output logic                  mem_err
);

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

   state_e                state_reg, state_next;
   logic [LINE_W-1:0]     victim_line_reg;
   logic [TAG_W-1:0]      victim_tag_reg;
   logic [LINE_W-1:0]     fill_line_reg;
   logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
   logic                  mem_err_reg;

   logic                  req;
   logic                  is_store;
   logic                  lookup_miss;
   logic                  mem_wait;
   logic [LADDR_W-1:0]    req_laddr;
   logic [WORD_SEL_W-1:0] word_sel;
   logic [LINE_W-1:0]     merge_src;
   logic [LINE_W-1:0]     merged_line;
   logic [WORD_W-1:0]     sel_word;
   logic                  unused_addr_hi;

   assign req            = cpu_re | cpu_we;
   assign is_store       = cpu_we;
   assign req_laddr      = cpu_addr[LADDR_MSB:LADDR_LSB];
   assign word_sel       = cpu_addr[WORD_SEL_W-1:0];
   assign unused_addr_hi = ^cpu_addr[CPU_ADDR_W-1:LADDR_MSB+1];
   assign lookup_miss    = (state_reg == IDLE) && req && !c_hit;
   assign mem_wait       = (state_reg == WB) || (state_reg == FILL);
   assign mem_err        = mem_err_reg;

   // A hit-store edits the line just read; ALLOC edits the line just filled.
   assign merge_src = (state_reg == ALLOC) ? fill_line_reg : c_rd_data;

   line_merge u_merge (
      .line_in    (merge_src),
      .word_sel   (word_sel),
      .new_word   (cpu_wdata),
      .replace_en (is_store),
      .word_out   (sel_word),
      .line_out   (merged_line)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (lookup_miss) state_next = c_dirty ? WB : FILL;
         WB:      if (m_rdy) state_next = FILL;
         FILL:    if (m_rdy) state_next = ALLOC;
         ALLOC:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Timeout only raises a flag; the FSM keeps waiting for m_rdy.
   always_comb begin
      wait_cnt_next = '0;
      if (mem_wait && !m_rdy) begin
         wait_cnt_next = wait_step(wait_cnt_reg);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         victim_line_reg <= '0;
         victim_tag_reg  <= '0;
         fill_line_reg   <= '0;
         wait_cnt_reg    <= '0;
         mem_err_reg     <= 1'b0;
      end else begin
         if (lookup_miss) begin
            victim_line_reg <= c_rd_data;
            victim_tag_reg  <= c_tag_out;
         end
         if ((state_reg == FILL) && m_rdy) begin
            fill_line_reg <= m_rdata;
         end
         wait_cnt_reg <= wait_cnt_next;
         if (mem_wait && !m_rdy && (wait_cnt_next == WAIT_LIMIT)) begin
            mem_err_reg <= 1'b1;
         end
      end
   end

   // Outputs are held at zero while reset is asserted, even with a live request.
   always_comb begin
      cpu_rdata = '0;
      cpu_stall = 1'b0;
      c_addr    = '0;
      c_wr_data = '0;
      c_wdirty  = 1'b0;
      c_we      = 1'b0;
      c_re      = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      m_re      = 1'b0;
      m_we      = 1'b0;
`ifdef CACHE_SNOOP_EN
      c_search    = 1'b0;
      snoop_found = 1'b0;
`endif
      if (rst_n) begin
         unique case (state_reg)
            IDLE: begin
               if (req) begin
                  c_re   = 1'b1;
                  c_addr = req_laddr;
                  if (!c_hit) begin
                     cpu_stall = 1'b1;
                  end else if (is_store) begin
                     c_we      = 1'b1;
                     c_wr_data = merged_line;
                     c_wdirty  = 1'b1;
                  end else begin
                     cpu_rdata = sel_word;
                  end
               end
`ifdef CACHE_SNOOP_EN
               else if (snoop_req) begin
                  c_search    = 1'b1;
                  c_addr      = snoop_addr;
                  snoop_found = c_hit;
               end
`endif
            end
            WB: begin
               cpu_stall = 1'b1;
               m_we      = 1'b1;
               m_addr    = {victim_tag_reg, req_laddr[IDX_W-1:0]};
               m_wdata   = victim_line_reg;
            end
            FILL: begin
               cpu_stall = 1'b1;
               m_re      = 1'b1;
               m_addr    = req_laddr;
            end
            ALLOC: begin
               cpu_stall = 1'b1;
               c_we      = 1'b1;
               c_addr    = req_laddr;
               c_wr_data = merged_line;
               c_wdirty  = is_store;
            end
            default: ;
         endcase
      end
   end

endmodule
